// File: rtl/miriscv_gpr_wb_arb.sv
//==============================================================================
// Module   : miriscv_gpr_wb_arb
// Purpose  : GPR writeback arbiter (ALU/LSU) with load-destination scoreboard.
//            Define MIRISCV_GPR_ARB_RR_EN for round-robin instead of LSU priority.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module miriscv_gpr_wb_arb #(
    parameter int XLEN           = 32,
    parameter int GPR_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      arstn_i,

    input  logic                      alu_valid_i,
    output logic                      alu_ready_o,
    input  logic [GPR_ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [XLEN-1:0]           alu_data_i,

    input  logic                      lsu_valid_i,
    output logic                      lsu_ready_o,
    input  logic [GPR_ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [XLEN-1:0]           lsu_data_i,

    input  logic                      lsu_issue_i,
    input  logic [GPR_ADDR_WIDTH-1:0] lsu_issue_addr_i,
    output logic                      lsu_issue_ready_o,

    input  logic [GPR_ADDR_WIDTH-1:0] r1_addr_i,
    input  logic [GPR_ADDR_WIDTH-1:0] r2_addr_i,
    output logic                      r1_busy_o,
    output logic                      r2_busy_o,

    output logic                      gpr_wr_en_o,
    output logic [GPR_ADDR_WIDTH-1:0] gpr_wr_addr_o,
    output logic [XLEN-1:0]           gpr_wr_data_o
);

    localparam int c_NREG = 1 << GPR_ADDR_WIDTH;

    logic                      w_grant_alu;
    logic                      w_grant_lsu;
    logic                      w_accept;
    logic [GPR_ADDR_WIDTH-1:0] w_addr;
    logic [XLEN-1:0]           w_data;
    logic                      w_issue_set;
    logic [c_NREG-1:0]         w_pending_nxt;

    logic [c_NREG-1:0]         r_pending;
    logic                      r_wr_en;
    logic [GPR_ADDR_WIDTH-1:0] r_wr_addr;
    logic [XLEN-1:0]           r_wr_data;

`ifdef MIRISCV_GPR_ARB_RR_EN
    // Set when the LSU won the most recent grant; reset means ALU-last.
    logic r_last_lsu;

    always_comb begin
        w_grant_lsu = lsu_valid_i & (~alu_valid_i | ~r_last_lsu);
        w_grant_alu = alu_valid_i & ~w_grant_lsu;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_last_lsu <= 1'b0;
        end else if (w_grant_lsu) begin
            r_last_lsu <= 1'b1;
        end else if (w_grant_alu) begin
            r_last_lsu <= 1'b0;
        end
    end
`else
    assign w_grant_lsu = lsu_valid_i;
    assign w_grant_alu = alu_valid_i & ~lsu_valid_i;
`endif

    assign alu_ready_o = w_grant_alu;
    assign lsu_ready_o = w_grant_lsu;
    assign w_accept    = w_grant_alu | w_grant_lsu;
    assign w_addr      = w_grant_lsu ? lsu_addr_i : alu_addr_i;
    assign w_data      = w_grant_lsu ? lsu_data_i : alu_data_i;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_accept & (w_addr != '0);
            if (w_accept) begin
                r_wr_addr <= w_addr;
                r_wr_data <= w_data;
            end
        end
    end

    assign gpr_wr_en_o   = r_wr_en;
    assign gpr_wr_addr_o = r_wr_addr;
    assign gpr_wr_data_o = r_wr_data;

    assign lsu_issue_ready_o = (lsu_issue_addr_i == '0) | ~r_pending[lsu_issue_addr_i];
    assign w_issue_set       = lsu_issue_i & lsu_issue_ready_o & (lsu_issue_addr_i != '0);

    // Set is applied after clear so a same-cycle reissue keeps the reservation.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_grant_lsu) begin
            w_pending_nxt[lsu_addr_i] = 1'b0;
        end
        if (w_issue_set) begin
            w_pending_nxt[lsu_issue_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    assign r1_busy_o = (r1_addr_i != '0) &
                       (r_pending[r1_addr_i] | (r_wr_en & (r_wr_addr == r1_addr_i)));
    assign r2_busy_o = (r2_addr_i != '0) &
                       (r_pending[r2_addr_i] | (r_wr_en & (r_wr_addr == r2_addr_i)));

endmodule

`default_nettype wire

// File: tb/tb_miriscv_gpr_wb_arb.sv
// Directed self-checking bench for miriscv_gpr_wb_arb.
`default_nettype none

module tb_miriscv_gpr_wb_arb;

    logic        clk_i = 1'b0;
    logic        arstn_i;
    logic        alu_valid_i, lsu_valid_i, lsu_issue_i;
    logic        alu_ready_o, lsu_ready_o, lsu_issue_ready_o;
    logic [4:0]  alu_addr_i, lsu_addr_i, lsu_issue_addr_i, r1_addr_i, r2_addr_i;
    logic [31:0] alu_data_i, lsu_data_i;
    logic        r1_busy_o, r2_busy_o;
    logic        gpr_wr_en_o;
    logic [4:0]  gpr_wr_addr_o;
    logic [31:0] gpr_wr_data_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    miriscv_gpr_wb_arb #(.XLEN(32), .GPR_ADDR_WIDTH(5)) dut (
        .clk_i             (clk_i),
        .arstn_i           (arstn_i),
        .alu_valid_i       (alu_valid_i),
        .alu_ready_o       (alu_ready_o),
        .alu_addr_i        (alu_addr_i),
        .alu_data_i        (alu_data_i),
        .lsu_valid_i       (lsu_valid_i),
        .lsu_ready_o       (lsu_ready_o),
        .lsu_addr_i        (lsu_addr_i),
        .lsu_data_i        (lsu_data_i),
        .lsu_issue_i       (lsu_issue_i),
        .lsu_issue_addr_i  (lsu_issue_addr_i),
        .lsu_issue_ready_o (lsu_issue_ready_o),
        .r1_addr_i         (r1_addr_i),
        .r2_addr_i         (r2_addr_i),
        .r1_busy_o         (r1_busy_o),
        .r2_busy_o         (r2_busy_o),
        .gpr_wr_en_o       (gpr_wr_en_o),
        .gpr_wr_addr_o     (gpr_wr_addr_o),
        .gpr_wr_data_o     (gpr_wr_data_o)
    );

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        arstn_i = 1'b0;
        alu_valid_i = 0; lsu_valid_i = 0; lsu_issue_i = 0;
        alu_addr_i = 0; lsu_addr_i = 0; lsu_issue_addr_i = 5'd3;
        alu_data_i = 0; lsu_data_i = 0;
        r1_addr_i = 5'd3; r2_addr_i = 5'd4;
        step(); step();
        checks++;
        if (gpr_wr_en_o !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", gpr_wr_en_o); end
        checks++;
        if (lsu_issue_ready_o !== 1'b1) begin failures++; $display("FAIL reset_issue_ready got=%b exp=1", lsu_issue_ready_o); end
        checks++;
        if ({r1_busy_o, r2_busy_o} !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b exp=00", {r1_busy_o, r2_busy_o}); end
        checks++;
        if (gpr_wr_addr_o !== 5'd0 || gpr_wr_data_o !== 32'd0) begin
            failures++; $display("FAIL reset_wr_addr_data got=%0d/%h exp=0/0", gpr_wr_addr_o, gpr_wr_data_o);
        end
        #3 arstn_i = 1'b1;
        step();
        checks++;
        if (gpr_wr_en_o !== 1'b0) begin failures++; $display("FAIL post_reset_wr_en got=%b exp=0", gpr_wr_en_o); end
    endtask

    task automatic test_alu_single();
        alu_valid_i = 1; alu_addr_i = 5'd5; alu_data_i = 32'hDEADBEEF;
        #1;
        checks++;
        if (alu_ready_o !== 1'b1 || lsu_ready_o !== 1'b0) begin
            failures++; $display("FAIL alu_single_ready got alu=%b lsu=%b exp alu=1 lsu=0", alu_ready_o, lsu_ready_o);
        end
        step();
        alu_valid_i = 0;
        checks++;
        if (gpr_wr_en_o !== 1'b1 || gpr_wr_addr_o !== 5'd5 || gpr_wr_data_o !== 32'hDEADBEEF) begin
            failures++; $display("FAIL alu_single_write got en=%b addr=%0d data=%h exp en=1 addr=5 data=deadbeef",
                                 gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o);
        end
        step();
        checks++;
        if (gpr_wr_en_o !== 1'b0) begin failures++; $display("FAIL alu_single_idle got=%b exp=0", gpr_wr_en_o); end
    endtask

    task automatic test_priority();
        logic [2:0] exp_lsu;
`ifdef MIRISCV_GPR_ARB_RR_EN
        exp_lsu = 3'b101;
`else
        exp_lsu = 3'b111;
`endif
        alu_valid_i = 1; alu_addr_i = 5'd1; alu_data_i = 32'h1111_0001;
        lsu_valid_i = 1; lsu_addr_i = 5'd2; lsu_data_i = 32'h2222_0002;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (lsu_ready_o !== exp_lsu[i] || alu_ready_o !== ~exp_lsu[i]) begin
                failures++; $display("FAIL prio_ready[%0d] got lsu=%b alu=%b exp lsu=%b alu=%b",
                                     i, lsu_ready_o, alu_ready_o, exp_lsu[i], ~exp_lsu[i]);
            end
            step();
            checks++;
            if (gpr_wr_en_o !== 1'b1 || gpr_wr_addr_o !== (exp_lsu[i] ? 5'd2 : 5'd1)) begin
                failures++; $display("FAIL prio_write[%0d] got en=%b addr=%0d exp en=1 addr=%0d",
                                     i, gpr_wr_en_o, gpr_wr_addr_o, exp_lsu[i] ? 2 : 1);
            end
        end
        alu_valid_i = 0; lsu_valid_i = 0;
        step();
    endtask

    task automatic test_pending();
        lsu_issue_i = 1; lsu_issue_addr_i = 5'd7;
        #1;
        checks++;
        if (lsu_issue_ready_o !== 1'b1) begin failures++; $display("FAIL pend_issue_ready got=%b exp=1", lsu_issue_ready_o); end
        step();
        r1_addr_i = 5'd7; r2_addr_i = 5'd8;
        #1;
        checks++;
        if (r1_busy_o !== 1'b1 || r2_busy_o !== 1'b0) begin
            failures++; $display("FAIL pend_busy got r1=%b r2=%b exp r1=1 r2=0", r1_busy_o, r2_busy_o);
        end
        checks++;
        if (lsu_issue_ready_o !== 1'b0) begin failures++; $display("FAIL pend_waw_block got=%b exp=0", lsu_issue_ready_o); end
        step();
        lsu_issue_i = 0;
        alu_valid_i = 1; alu_addr_i = 5'd7; alu_data_i = 32'h0A;
        step();
        alu_valid_i = 0;
        step();
        checks++;
        if (r1_busy_o !== 1'b1) begin failures++; $display("FAIL pend_alu_no_clear got=%b exp=1", r1_busy_o); end
        lsu_valid_i = 1; lsu_addr_i = 5'd7; lsu_data_i = 32'h7777_0007;
        #1;
        checks++;
        if (lsu_ready_o !== 1'b1 || r1_busy_o !== 1'b1) begin
            failures++; $display("FAIL pend_wb_accept got ready=%b busy=%b exp ready=1 busy=1", lsu_ready_o, r1_busy_o);
        end
        step();
        lsu_valid_i = 0;
        #1;
        checks++;
        if (r1_busy_o !== 1'b1 || gpr_wr_en_o !== 1'b1 || gpr_wr_addr_o !== 5'd7) begin
            failures++; $display("FAIL pend_out_stage got busy=%b en=%b addr=%0d exp busy=1 en=1 addr=7",
                                 r1_busy_o, gpr_wr_en_o, gpr_wr_addr_o);
        end
        step();
        checks++;
        if (r1_busy_o !== 1'b0 || lsu_issue_ready_o !== 1'b1) begin
            failures++; $display("FAIL pend_released got busy=%b issue_ready=%b exp busy=0 issue_ready=1",
                                 r1_busy_o, lsu_issue_ready_o);
        end
    endtask

    task automatic test_addr0();
        alu_valid_i = 1; alu_addr_i = 5'd0; alu_data_i = 32'h1234_5678;
        r1_addr_i = 5'd0;
        lsu_issue_i = 1; lsu_issue_addr_i = 5'd0;
        #1;
        checks++;
        if (alu_ready_o !== 1'b1 || lsu_issue_ready_o !== 1'b1) begin
            failures++; $display("FAIL addr0_ready got alu=%b issue=%b exp 1/1", alu_ready_o, lsu_issue_ready_o);
        end
        step();
        alu_valid_i = 0; lsu_issue_i = 0;
        #1;
        checks++;
        if (gpr_wr_en_o !== 1'b0) begin failures++; $display("FAIL addr0_wr_en got=%b exp=0", gpr_wr_en_o); end
        checks++;
        if (r1_busy_o !== 1'b0) begin failures++; $display("FAIL addr0_busy got=%b exp=0", r1_busy_o); end
        step();
    endtask

    task automatic test_same_cycle();
        lsu_valid_i = 1; lsu_addr_i = 5'd9; lsu_data_i = 32'h9999_0009;
        lsu_issue_i = 1; lsu_issue_addr_i = 5'd9;
        r1_addr_i = 5'd9;
        step();
        lsu_valid_i = 0; lsu_issue_i = 0;
        step(); step();
        checks++;
        if (r1_busy_o !== 1'b1 || lsu_issue_ready_o !== 1'b0) begin
            failures++; $display("FAIL same_cycle_set got busy=%b issue_ready=%b exp busy=1 issue_ready=0",
                                 r1_busy_o, lsu_issue_ready_o);
        end
        lsu_valid_i = 1;
        step();
        lsu_valid_i = 0;
        step();
        checks++;
        if (r1_busy_o !== 1'b0) begin failures++; $display("FAIL same_cycle_cleanup got=%b exp=0", r1_busy_o); end
    endtask

    task automatic test_reset_mid();
        lsu_issue_i = 1; lsu_issue_addr_i = 5'd11;
        alu_valid_i = 1; alu_addr_i = 5'd4; alu_data_i = 32'h4444_0004;
        step();
        lsu_issue_i = 0; alu_valid_i = 0;
        r1_addr_i = 5'd4; r2_addr_i = 5'd11;
        #1;
        checks++;
        if (gpr_wr_en_o !== 1'b1 || r1_busy_o !== 1'b1 || r2_busy_o !== 1'b1) begin
            failures++; $display("FAIL rmid_pre got en=%b r1=%b r2=%b exp 1/1/1", gpr_wr_en_o, r1_busy_o, r2_busy_o);
        end
        arstn_i = 1'b0;
        #1;
        checks++;
        if (gpr_wr_en_o !== 1'b0) begin failures++; $display("FAIL rmid_wr_en got=%b exp=0", gpr_wr_en_o); end
        lsu_issue_addr_i = 5'd11;
        #1;
        checks++;
        if (r1_busy_o !== 1'b0 || r2_busy_o !== 1'b0 || lsu_issue_ready_o !== 1'b1) begin
            failures++; $display("FAIL rmid_in_reset got r1=%b r2=%b issue=%b exp 0/0/1", r1_busy_o, r2_busy_o, lsu_issue_ready_o);
        end
        step(); step();
        #3 arstn_i = 1'b1;
        step();
        checks++;
        if (gpr_wr_en_o !== 1'b0 || r1_busy_o !== 1'b0 || r2_busy_o !== 1'b0) begin
            failures++; $display("FAIL rmid_release got en=%b r1=%b r2=%b exp 0/0/0", gpr_wr_en_o, r1_busy_o, r2_busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_alu_single();
        test_priority();
        test_pending();
        test_addr0();
        test_same_cycle();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/miriscv_gpr_wb_arb.md
MIRISCV_GPR_WB_ARB -- requirements
Module: miriscv_gpr_wb_arb

Interface
- REQ-001 SHALL have parameter XLEN, default 32, GPR data width.
- REQ-002 SHALL have parameter GPR_ADDR_WIDTH, default 5, GPR address width (32 registers).
- REQ-003 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
- REQ-004 SHALL have port arstn_i  input  1  reset, asynchronous, active-low.
- REQ-005 SHALL have ports alu_valid_i in 1, alu_ready_o out 1, alu_addr_i in GPR_ADDR_WIDTH, alu_data_i in XLEN  ALU writeback request.
- REQ-006 SHALL have ports lsu_valid_i in 1, lsu_ready_o out 1, lsu_addr_i in GPR_ADDR_WIDTH, lsu_data_i in XLEN  LSU load-data writeback request.
- REQ-007 SHALL have ports lsu_issue_i in 1, lsu_issue_addr_i in GPR_ADDR_WIDTH, lsu_issue_ready_o out 1  load issue; reserves destination register.
- REQ-008 SHALL have ports r1_addr_i, r2_addr_i in GPR_ADDR_WIDTH; r1_busy_o, r2_busy_o out 1  operand hazard query.
- REQ-009 SHALL have ports gpr_wr_en_o out 1, gpr_wr_addr_o out GPR_ADDR_WIDTH, gpr_wr_data_o out XLEN  drives GPR write port.

Function
- REQ-010 SHALL grant at most one writeback request per cycle; request accepted when valid and ready both high.
- REQ-011 SHALL drive ready combinationally: ready high only for the granted source; ungranted source ready low.
- REQ-012 SHALL grant by fixed priority LSU over ALU when both valid (default build).
- REQ-013 SHALL register accepted request into output stage: gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o valid exactly 1 cycle after acceptance, for exactly 1 cycle unless another acceptance follows.
- REQ-014 SHALL accept requests to address 0 (ready high) but keep gpr_wr_en_o low for them; gpr_wr_addr_o/gpr_wr_data_o don't-care then.
- REQ-015 SHALL hold gpr_wr_en_o low in any cycle following a cycle with no acceptance.
- REQ-016 SHALL keep a pending bit per register: set on lsu_issue_i & lsu_issue_ready_o with nonzero lsu_issue_addr_i; cleared on LSU writeback acceptance to that address.
- REQ-017 SHALL give set priority when issue and LSU acceptance target the same register in the same cycle (bit ends set).
- REQ-018 SHALL drive lsu_issue_ready_o low when pending[lsu_issue_addr_i] is set (WAW block), high otherwise; issue to address 0 always ready and reserves nothing.
- REQ-019 SHALL drive rN_busy_o = pending[rN_addr_i] OR (gpr_wr_en_o AND gpr_wr_addr_o == rN_addr_i); forced 0 when rN_addr_i == 0.
- REQ-020 SHALL NOT alter pending bits on ALU writebacks.

Reset
- REQ-021 SHALL on arstn_i low immediately clear all pending bits, gpr_wr_en_o, gpr_wr_addr_o, gpr_wr_data_o and the round-robin pointer (pointer = ALU-last).
- REQ-022 SHALL discard any in-flight output-stage write on reset mid-operation; no GPR write occurs in the first cycle after reset release.
- REQ-023 SHALL drive busy outputs 0 and issue-ready 1 while in reset.

Configuration
- REQ-024 SHALL, with macro MIRISCV_GPR_ARB_RR_EN defined, replace REQ-012 with round-robin: when both valid, grant the source not granted most recently; single valid source always granted; pointer updates only on acceptance.
- REQ-025 SHALL, without MIRISCV_GPR_ARB_RR_EN, use fixed LSU priority and contain no pointer state.

Verification
- REQ-026 SHALL cover: ALU valid addr 5 data 0xDEADBEEF alone -> alu_ready_o=1 same cycle; next cycle gpr_wr_en_o=1, addr 5, data 0xDEADBEEF.
- REQ-027 SHALL cover: ALU and LSU valid 3 consecutive cycles (addr 1/2) -> default: LSU granted all 3, alu_ready_o=0; with RR: grants LSU, ALU, LSU.
- REQ-028 SHALL cover: lsu_issue addr 7, then r1_addr 7 -> r1_busy_o=1; second issue to 7 -> lsu_issue_ready_o=0; LSU writeback addr 7 accepted -> busy stays 1 next cycle (output stage), 0 the cycle after.
- REQ-029 SHALL cover: ALU writeback to addr 0 -> alu_ready_o=1, gpr_wr_en_o stays 0; r1_addr 0 -> r1_busy_o=0.
- REQ-030 SHALL cover: same-cycle LSU accept to addr 9 and new issue to addr 9 -> pending[9] remains set.
- REQ-031 SHALL cover: arstn_i asserted while output stage holds write to addr 4 -> gpr_wr_en_o=0 immediately, all busy 0 after release.
